pooler: RTL and testbench
=========================

# pooler

Streaming 2×2, stride-2 max-pooling stage of the CNN accelerator datapath. It accepts one feature-map pixel per enabled clock in row-major raster order. Each non-overlapping 2×2 window yields its signed maximum, so an IMG_W×IMG_H map is reduced to (IMG_W/2)×(IMG_H/2). It sits between a convolution/activation stage and the next layer's input buffer; frames restart automatically.

## Interface
- DATA_W, 32, pixel width (signed two's complement)
- IMG_W, 12, input map width in pixels (even, ≥2)
- IMG_H, 12, input map height in pixels (even, ≥2)

- clk  in  1  single clock, rising-edge
- master_rst  in  1  reset, asynchronous, active-low (asserted when 0)
- ce  in  1  input enable: data_in is consumed at a rising edge when ce=1
- data_in  in  DATA_W  input pixel, signed
- data_out  out  DATA_W  pooled maximum, signed, registered
- valid_op  out  1  one-cycle strobe: data_out holds a new result
- end_op  out  1  one-cycle strobe coincident with the last result of a frame

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the next pixel; they advance only on ce=1. col wraps to 0 and increments row; row wraps to 0 after IMG_H-1, starting a new frame with no gap.
- Even col: store pixel in hold register h.
- Odd col: pair = max(h, data_in), signed comparison.
  - Even row: line buffer lb[col/2] ← pair (depth IMG_W/2, DATA_W each).
  - Odd row: data_out ← max(lb[col/2], pair); valid_op ← 1.
- end_op ← 1 when the sample is at row=IMG_H-1, col=IMG_W-1.
- Ties: either operand may be chosen; the values are equal.
- Output order: row-major over the pooled grid, (IMG_W/2)·(IMG_H/2) results per frame (36 for 12×12).
- No overflow is possible; results are always one of the inputs, at full DATA_W.

## Timing
- Reset (master_rst=0, asynchronous): data_out=0, valid_op=0, end_op=0, col=0, row=0, h=0. Line buffer contents are don't-care; they are always rewritten before being read.
- Latency: 1 clock. The bottom-right pixel of a window is sampled at edge k, and data_out/valid_op are valid immediately after edge k, for one cycle.
- valid_op and end_op are 0 on every other cycle, including every cycle with ce=0.
- data_out holds its last value between strobes.
- ce=0: full stall. Counters, h, lb and data_out are unchanged.
- ce gaps may occur anywhere, including between the two pixels of a pair. Results are identical to the gap-free stream; only timing shifts.
- Reset mid-frame: all partial state is discarded. The next ce=1 sample is treated as pixel (0,0) of a new frame.
- Throughput: one pixel per clock, no back-pressure. There is no input-ready output; the upstream stage may stream continuously.
- First result of a frame: after the (IMG_W+2)-th accepted pixel (the 14th for 12×12).
- Last result: on the final pixel of the frame, together with end_op.

## Test plan
- Ramp: reset, then ce=1 with data_in=0..143 on consecutive clocks.
  - Outputs 13,15,17,19,21,23, then 37..47 step 2, …, last 143.
  - 36 valid_op strobes; end_op only with 143.
  - First strobe one cycle after pixel 13 is sampled.
- Signed values: 12×12 frame of negative values, with one window {-5,-2,-9,-7}.
  - That window outputs -2. A window containing 32'h8000_0000 and 0 outputs 0.
- Stalls: ramp frame with ce toggling 1/0 every cycle, plus a 5-cycle gap inside a pair.
  - Same 36 values as the ramp; no strobes while ce=0.
- Back-to-back frames: two ramp frames, 0..143 then 1000..1143, with no gap.
  - Second frame outputs 1013…1143; end_op strobes exactly twice.
- Reset mid-frame: reset asserted after 50 pixels, then a full ramp frame.
  - Outputs all 0 and no strobes while reset is asserted.
  - Afterwards, exactly the ramp results.
- Max location: in each window the maximum is placed at top-left, top-right, bottom-left and bottom-right in turn.
  - Each window outputs the planted maximum.

Source files
------------

// File: rtl/pooler_if.sv
// Pixel stream bundle for the 2x2 max-pooling stage.
// master drives pixels, slave returns pooled results.
interface pooler_if #(
  parameter int DATA_W = 32
);
  logic              ce;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_op;
  logic              end_op;

  modport master (
    output ce, data_in,
    input  data_out, valid_op, end_op
  );

  modport slave (
    input  ce, data_in,
    output data_out, valid_op, end_op
  );
endinterface

// File: rtl/pooler.sv
// Streaming 2x2 stride-2 signed max pooling over a raster pixel stream.
// One pixel per enabled clock; one result per window, 1-clock latency.
module pooler #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12
) (
  input  logic     clk,
  input  logic     master_rst,
  pooler_if.slave  bus
);
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LD = IMG_W / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] idx;
  logic          last_col;
  logic          last_row;

  logic signed [DATA_W-1:0] h;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] pair;
  logic signed [DATA_W-1:0] up;
  logic signed [DATA_W-1:0] win;
  logic signed [DATA_W-1:0] dout;
  logic signed [DATA_W-1:0] lb [LD];

  logic valid;
  logic fin;

  assign din      = $signed(bus.data_in);
  assign idx      = LW'(col >> 1);
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));

  assign pair = (din > h) ? din : h;
  assign up   = lb[idx];
  assign win  = (up > pair) ? up : pair;

  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      col   <= '0;
      row   <= '0;
      h     <= '0;
      dout  <= '0;
      valid <= 1'b0;
      fin   <= 1'b0;
    end else begin
      valid <= 1'b0;
      fin   <= 1'b0;
      if (bus.ce) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) h <= din;
        if (col[0] && row[0]) begin
          dout  <= win;
          valid <= 1'b1;
        end
        fin <= last_col && last_row;
      end
    end
  end

  // Line buffer needs no reset: every entry is written on an even row
  // before the matching odd row reads it.
  always_ff @(posedge clk) begin
    if (bus.ce && col[0] && !row[0]) lb[idx] <= pair;
  end

  assign bus.data_out = dout;
  assign bus.valid_op = valid;
  assign bus.end_op   = fin;
endmodule

// File: tb/tb_pooler.sv
// Randomized bench for pooler against a frame-image reference model.
// Checks strobes, data and end markers every cycle.
module tb_pooler;
  localparam int DW = 32;
  localparam int W  = 12;
  localparam int H  = 12;
  localparam int N  = W * H;
  localparam int NP = (W / 2) * (H / 2);

  logic clk = 1'b0;
  logic master_rst;
  always #5 clk = ~clk;

  pooler_if #(.DATA_W(DW)) bus ();

  pooler #(
    .DATA_W(DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .master_rst(master_rst),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  int pos;
  int nstb;
  int nend;
  logic signed [DW-1:0] img [H][W];
  logic        [DW-1:0] exp_out;
  logic        [DW-1:0] fr [N];
  logic        [DW-1:0] got_q [$];

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic step(input logic [DW-1:0] v, input bit c);
    bit ev;
    bit ee;
    int r;
    int k;
    bus.ce      = c;
    bus.data_in = v;
    @(posedge clk);
    #1;
    ev = 1'b0;
    ee = 1'b0;
    if (c) begin
      r = pos / W;
      k = pos % W;
      img[r][k] = v;
      if (r % 2 == 1 && k % 2 == 1) begin
        ev = 1'b1;
        exp_out = smax(smax(img[r-1][k-1], img[r-1][k]),
                       smax(img[r][k-1], img[r][k]));
      end
      ee  = (pos == N - 1);
      pos = (pos + 1) % N;
    end
    if (bus.valid_op === 1'b1) begin
      nstb++;
      got_q.push_back(bus.data_out);
    end
    if (bus.end_op === 1'b1) nend++;
    chk("valid_op", DW'(bus.valid_op), DW'(ev));
    chk("end_op", DW'(bus.end_op), DW'(ee));
    chk("data_out", bus.data_out, exp_out);
  endtask

  task automatic idle();
    step($urandom, 1'b0);
  endtask

  // mode 0: continuous, 1: alternate ce with a 5-cycle gap in a pair,
  // 2: random gaps
  task automatic drive_frame(input int mode);
    for (int i = 0; i < N; i++) begin
      if (mode == 2) begin
        while ($urandom_range(0, 2) == 0) idle();
      end
      step(fr[i], 1'b1);
      if (mode == 1) begin
        if (i == 2) repeat (5) idle();
        else idle();
      end
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < N; i++) fr[i] = DW'(base + i);
  endtask

  task automatic clr();
    nstb = 0;
    nend = 0;
    got_q.delete();
  endtask

  task automatic ramp_results(input string tag, input int base, input int off);
    int want;
    for (int j = 0; j < NP; j++) begin
      want = base + (2 * (j / (W / 2)) + 1) * W + 2 * (j % (W / 2)) + 1;
      if (off + j < got_q.size())
        chk(tag, got_q[off + j], DW'(want));
      else
        chk({tag, "_missing"}, 32'hdead_beef, DW'(want));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, bus.data_out, '0);
    chk({tag, "_valid"}, DW'(bus.valid_op), '0);
    chk({tag, "_end"}, DW'(bus.end_op), '0);
  endtask

  initial begin
    int w;
    int r;
    int k;
    int sel;
    master_rst  = 1'b0;
    bus.ce      = 1'b0;
    bus.data_in = '0;
    pos         = 0;
    exp_out     = '0;
    clr();
    #12;
    chk_zero("reset");
    @(negedge clk);
    master_rst = 1'b1;

    // ramp
    clr();
    fill_ramp(0);
    drive_frame(0);
    chk("ramp_strobes", DW'(nstb), DW'(NP));
    chk("ramp_ends", DW'(nend), 1);
    ramp_results("ramp_val", 0, 0);

    // negative values with planted windows
    clr();
    for (int i = 0; i < N; i++) fr[i] = -DW'($urandom_range(1, 1000));
    fr[0]  = -32'sd5;
    fr[1]  = -32'sd2;
    fr[W]  = -32'sd9;
    fr[W+1] = -32'sd7;
    fr[2]  = 32'h8000_0000;
    fr[W+3] = '0;
    drive_frame(0);
    chk("neg_win0", got_q[0], -32'sd2);
    chk("neg_win1", got_q[1], '0);

    // stalls
    clr();
    fill_ramp(0);
    drive_frame(1);
    chk("stall_strobes", DW'(nstb), DW'(NP));
    ramp_results("stall_val", 0, 0);

    // back-to-back
    clr();
    fill_ramp(0);
    drive_frame(0);
    fill_ramp(1000);
    drive_frame(0);
    chk("b2b_ends", DW'(nend), 2);
    chk("b2b_strobes", DW'(nstb), DW'(2 * NP));
    ramp_results("b2b_f1", 0, 0);
    ramp_results("b2b_f2", 1000, NP);

    // reset mid-frame
    for (int i = 0; i < 50; i++) step(DW'(i), 1'b1);
    master_rst = 1'b0;
    #1;
    pos     = 0;
    exp_out = '0;
    chk_zero("mid_rst");
    repeat (3) begin
      bus.ce      = 1'b1;
      bus.data_in = $urandom;
      @(posedge clk);
      #1;
      chk_zero("in_rst");
    end
    @(negedge clk);
    master_rst = 1'b1;
    clr();
    fill_ramp(0);
    drive_frame(0);
    chk("rst_strobes", DW'(nstb), DW'(NP));
    chk("rst_ends", DW'(nend), 1);
    ramp_results("rst_val", 0, 0);

    // max location rotates through the four window positions
    clr();
    for (int i = 0; i < N; i++)
      fr[i] = DW'(int'($urandom_range(0, 2000)) - 1000);
    for (int j = 0; j < NP; j++) begin
      sel = j % 4;
      r = 2 * (j / (W / 2)) + sel / 2;
      k = 2 * (j % (W / 2)) + sel % 2;
      fr[r * W + k] = DW'(5000 + j);
    end
    drive_frame(0);
    for (int j = 0; j < NP; j++) begin
      w = 5000 + j;
      if (j < got_q.size()) chk("maxloc", got_q[j], DW'(w));
      else chk("maxloc_missing", 32'hdead_beef, DW'(w));
    end

    // fully random data with random gaps
    repeat (2) begin
      clr();
      for (int i = 0; i < N; i++) fr[i] = $urandom;
      drive_frame(2);
      chk("rand_strobes", DW'(nstb), DW'(NP));
      chk("rand_ends", DW'(nend), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
